// File: rtl/pmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// pmem_arbiter_pkg
//   Shared types for the physical-memory arbiter.
//   - lc3b_word      : 16-bit address/data word
//   - lc3b_line      : 128-bit cache line
//   - lc3b_arb_state : arbiter FSM states
//   - streak_width() : width of the starvation streak counter, never below 1
// -----------------------------------------------------------------------------
package pmem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } lc3b_arb_state;

  // A limit of 0 still needs a one-bit counter so the port widths stay legal.
  function automatic int streak_width(input int max_streak);
    if (max_streak < 1) begin
      return 1;
    end
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/pmem_arbiter_streak.sv
// -----------------------------------------------------------------------------
// arb_streak_counter
//   Saturating up-counter tracking consecutive contended D-cache grants.
//   Ports:
//     clk       in   clock
//     rst_n     in   synchronous reset, active-low
//     i_clr     in   clear to zero (wins over increment)
//     i_inc     in   increment, holds at MAX_COUNT
//     o_at_max  out  count has reached MAX_COUNT
// -----------------------------------------------------------------------------
module arb_streak_counter
  import pmem_arbiter_pkg::*;
#(
  parameter int MAX_COUNT = 4,
  parameter int W         = streak_width(MAX_COUNT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_max
);

  localparam logic [W-1:0] LIMIT = W'(MAX_COUNT);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT)) begin
      r_count <= r_count + W'(1);
    end
  end

  // With MAX_COUNT == 0 this is permanently true, so I always wins contention.
  assign o_at_max = (r_count == LIMIT);

endmodule

// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//   Shares one physical-memory port between the I-cache (line fills) and the
//   D-cache (line fills and writebacks). One requester is served at a time;
//   its command, address and write data are captured at grant and replayed to
//   memory for the whole transaction. D-cache has priority, but after
//   MAX_STREAK consecutive contended D grants the I-cache is forced through.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ARB_IDLE    | no transaction; arbitrate, one decision per cycle
//   ARB_SERVE_I | I-cache fill in flight; leaves on pmem_resp
//   ARB_SERVE_D | D-cache fill/writeback in flight; leaves on pmem_resp
//
//   Ports:
//     clk, rst_n                       clock, synchronous active-low reset
//     i_pmem_read/address              I-cache request (held until resp)
//     i_pmem_resp/rdata                I-cache response
//     d_pmem_read/write/address/wdata  D-cache request (held until resp)
//     d_pmem_resp/rdata                D-cache response
//     pmem_read/write/address/wdata    command to memory
//     pmem_resp/rdata                  memory response
// -----------------------------------------------------------------------------
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic     clk,
  input  logic     rst_n,

  input  logic     i_pmem_read,
  input  lc3b_word i_pmem_address,
  output logic     i_pmem_resp,
  output lc3b_line i_pmem_rdata,

  input  logic     d_pmem_read,
  input  logic     d_pmem_write,
  input  lc3b_word d_pmem_address,
  input  lc3b_line d_pmem_wdata,
  output logic     d_pmem_resp,
  output lc3b_line d_pmem_rdata,

  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  logic     pmem_resp,
  input  lc3b_line pmem_rdata
);

  lc3b_arb_state r_state;
  lc3b_arb_state w_state_next;

  logic     r_op_write;
  lc3b_word r_addr;
  lc3b_line r_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_streak_clr;
  logic w_streak_inc;
  logic w_streak_at_max;

  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;

  arb_streak_counter #(
    .MAX_COUNT (MAX_STREAK)
  ) u_streak (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_streak_clr),
    .i_inc    (w_streak_inc),
    .o_at_max (w_streak_at_max)
  );

  // State register plus the command latches, captured only on the grant edge
  // so later changes on the request side cannot disturb memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ARB_IDLE) && (w_state_next == ARB_SERVE_D)) begin
        // Read and write both asserted is a protocol error; the write wins.
        r_op_write <= d_pmem_write;
        r_addr     <= d_pmem_address;
        r_wdata    <= d_pmem_wdata;
      end else if ((r_state == ARB_IDLE) && (w_state_next == ARB_SERVE_I)) begin
        r_op_write <= 1'b0;
        r_addr     <= i_pmem_address;
        r_wdata    <= '0;
      end
    end
  end

  // Next state and streak bookkeeping. Only contended D grants count towards
  // the streak; any I grant restarts it.
  always_comb begin
    w_state_next = r_state;
    w_streak_clr = 1'b0;
    w_streak_inc = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_d_req && w_i_req) begin
          if (w_streak_at_max) begin
            w_state_next = ARB_SERVE_I;
            w_streak_clr = 1'b1;
          end else begin
            w_state_next = ARB_SERVE_D;
            w_streak_inc = 1'b1;
          end
        end else if (w_d_req) begin
          w_state_next = ARB_SERVE_D;
        end else if (w_i_req) begin
          w_state_next = ARB_SERVE_I;
          w_streak_clr = 1'b1;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        // Returning through IDLE gives the mandatory one-cycle bubble.
        if (pmem_resp) begin
          w_state_next = ARB_IDLE;
        end
      end
      default: begin
        w_state_next = ARB_IDLE;
      end
    endcase
  end

  // Outputs decode only registered state and latches, so the memory command
  // is glitch-free and stable; only the response pulses follow pmem_resp.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (r_state)
      ARB_SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = r_addr;
        pmem_wdata   = r_wdata;
        i_pmem_resp  = pmem_resp;
      end
      ARB_SERVE_D: begin
        pmem_read    = ~r_op_write;
        pmem_write   = r_op_write;
        pmem_address = r_addr;
        pmem_wdata   = r_wdata;
        d_pmem_resp  = pmem_resp;
      end
      default: begin
      end
    endcase
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule
